// File: rtl/stierlitz_pkg.sv
// Shared definitions for the SACE/HPI bus arbiter: FSM state encodings and owner codes.
package stierlitz_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StOwnHpi = 2'b01,
    StOwnAce = 2'b10,
    StTurn   = 2'b11
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_HPI  = 2'b01;
  localparam logic [1:0] OWNER_ACE  = 2'b10;

endpackage

// File: rtl/sace_bus_mux.sv
// Registered steering of the shared bus: drives the selected owner's strobes/data one cycle
// later, or the released bus (strobes high, data not driven, address 0) when nobody is selected.
module sace_bus_mux
  import stierlitz_pkg::*;
(
  input  logic        sys_clk,
  input  logic        usbreset,
  input  logic [1:0]  sel,
  input  logic [1:0]  hpi_a,
  input  logic        hpi_oen,
  input  logic        hpi_wen,
  input  logic [15:0] hpi_dout,
  input  logic        hpi_doe,
  input  logic [6:0]  ace_a,
  input  logic        ace_oen,
  input  logic        ace_wen,
  input  logic [15:0] ace_dout,
  input  logic        ace_doe,
  output logic [6:0]  bus_a,
  output logic        bus_oen,
  output logic        bus_wen,
  output logic [15:0] bus_d_out,
  output logic        bus_d_oe
);

  logic [6:0]  bus_a_d, bus_a_q;
  logic        bus_oen_d, bus_oen_q;
  logic        bus_wen_d, bus_wen_q;
  logic [15:0] bus_d_out_d, bus_d_out_q;
  logic        bus_d_oe_d, bus_d_oe_q;

  // Select the owner's strobes; HPI's 2-bit address lands on bus_a[2:1].
  always_comb begin
    bus_a_d     = '0;
    bus_oen_d   = 1'b1;
    bus_wen_d   = 1'b1;
    bus_d_out_d = '0;
    bus_d_oe_d  = 1'b0;
    unique case (sel)
      OWNER_HPI: begin
        bus_a_d     = {4'b0000, hpi_a, 1'b0};
        bus_oen_d   = hpi_oen;
        bus_wen_d   = hpi_wen;
        bus_d_out_d = hpi_dout;
        bus_d_oe_d  = hpi_doe;
      end
      OWNER_ACE: begin
        bus_a_d     = ace_a;
        bus_oen_d   = ace_oen;
        bus_wen_d   = ace_wen;
        bus_d_out_d = ace_dout;
        bus_d_oe_d  = ace_doe;
      end
      default: ;
    endcase
  end

  // Bus drive registers; reset releases the bus immediately.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      bus_a_q     <= '0;
      bus_oen_q   <= 1'b1;
      bus_wen_q   <= 1'b1;
      bus_d_out_q <= '0;
      bus_d_oe_q  <= 1'b0;
    end else begin
      bus_a_q     <= bus_a_d;
      bus_oen_q   <= bus_oen_d;
      bus_wen_q   <= bus_wen_d;
      bus_d_out_q <= bus_d_out_d;
      bus_d_oe_q  <= bus_d_oe_d;
    end
  end

  assign bus_a     = bus_a_q;
  assign bus_oen   = bus_oen_q;
  assign bus_wen   = bus_wen_q;
  assign bus_d_out = bus_d_out_q;
  assign bus_d_oe  = bus_d_oe_q;

endmodule

// File: rtl/sace_bus_arbiter.sv
// Arbiter sharing one external bus between the CY7C67300 HPI port and the System ACE MPU port.
// Round-robin on ties, fixed turnaround gap between owners, registered grants/chip selects.
// Optional hold-time preempt hint is enabled by defining SACE_ARB_PREEMPT_EN.
module sace_bus_arbiter
  import stierlitz_pkg::*;
#(
  parameter int unsigned TURNAROUND_CYCLES = 4,
  parameter int unsigned MAX_HOLD          = 256
) (
  input  logic        sys_clk,
  input  logic        usbreset,
  input  logic        req_hpi,
  input  logic        req_ace,
  output logic        gnt_hpi,
  output logic        gnt_ace,
  output logic        preempt_hpi,
  output logic        preempt_ace,
  input  logic [1:0]  hpi_a,
  input  logic        hpi_oen,
  input  logic        hpi_wen,
  input  logic [15:0] hpi_dout,
  input  logic        hpi_doe,
  input  logic [6:0]  ace_a,
  input  logic        ace_oen,
  input  logic        ace_wen,
  input  logic [15:0] ace_dout,
  input  logic        ace_doe,
  output logic [6:0]  bus_a,
  output logic        bus_oen,
  output logic        bus_wen,
  output logic [15:0] bus_d_out,
  output logic        bus_d_oe,
  output logic        usb_csn,
  output logic        sace_mpce,
  output logic [1:0]  owner
);

  localparam int unsigned CntW     = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam int unsigned TurnLast = (TURNAROUND_CYCLES == 0) ? 0 : TURNAROUND_CYCLES - 1;

  arb_state_e      state_d, state_q;
  logic [1:0]      last_owner_d, last_owner_q;
  logic [CntW-1:0] turn_cnt_d, turn_cnt_q;
  logic            gnt_hpi_d, gnt_hpi_q, gnt_ace_d, gnt_ace_q;
  logic            usb_csn_d, usb_csn_q, sace_mpce_d, sace_mpce_q;
  logic [1:0]      owner_d, owner_q;
  logic [1:0]      mux_sel;

  // Next-state: arbitration in idle, release on request drop, timed turnaround.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    turn_cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (req_hpi && (!req_ace || last_owner_q == OWNER_ACE)) begin
          state_d      = StOwnHpi;
          last_owner_d = OWNER_HPI;
        end else if (req_ace) begin
          state_d      = StOwnAce;
          last_owner_d = OWNER_ACE;
        end
      end
      StOwnHpi: if (!req_hpi) state_d = (TURNAROUND_CYCLES == 0) ? StIdle : StTurn;
      StOwnAce: if (!req_ace) state_d = (TURNAROUND_CYCLES == 0) ? StIdle : StTurn;
      StTurn: begin
        if (turn_cnt_q == CntW'(TurnLast)) state_d = StIdle;
        else turn_cnt_d = turn_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs follow the next state; strobes pass only while ownership continues.
  always_comb begin
    gnt_hpi_d   = (state_d == StOwnHpi);
    gnt_ace_d   = (state_d == StOwnAce);
    usb_csn_d   = !gnt_hpi_d;
    sace_mpce_d = !gnt_ace_d;
    owner_d     = gnt_hpi_d ? OWNER_HPI : (gnt_ace_d ? OWNER_ACE : OWNER_NONE);
    mux_sel     = OWNER_NONE;
    if (state_q == StOwnHpi && state_d == StOwnHpi) mux_sel = OWNER_HPI;
    if (state_q == StOwnAce && state_d == StOwnAce) mux_sel = OWNER_ACE;
  end

  // State, round-robin memory and control output registers.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      state_q      <= StIdle;
      last_owner_q <= OWNER_ACE;
      turn_cnt_q   <= '0;
      gnt_hpi_q    <= 1'b0;
      gnt_ace_q    <= 1'b0;
      usb_csn_q    <= 1'b1;
      sace_mpce_q  <= 1'b1;
      owner_q      <= OWNER_NONE;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      turn_cnt_q   <= turn_cnt_d;
      gnt_hpi_q    <= gnt_hpi_d;
      gnt_ace_q    <= gnt_ace_d;
      usb_csn_q    <= usb_csn_d;
      sace_mpce_q  <= sace_mpce_d;
      owner_q      <= owner_d;
    end
  end

  assign gnt_hpi   = gnt_hpi_q;
  assign gnt_ace   = gnt_ace_q;
  assign usb_csn   = usb_csn_q;
  assign sace_mpce = sace_mpce_q;
  assign owner     = owner_q;

`ifdef SACE_ARB_PREEMPT_EN
  localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
  logic             preempt_hpi_d, preempt_hpi_q, preempt_ace_d, preempt_ace_q;

  // Count owned cycles while the other side waits; the hint sticks until the owner lets go.
  always_comb begin
    hold_cnt_d    = '0;
    preempt_hpi_d = 1'b0;
    preempt_ace_d = 1'b0;
    if (state_q == StOwnHpi && state_d == StOwnHpi) begin
      hold_cnt_d = hold_cnt_q;
      if (req_ace && hold_cnt_q != HoldW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + 1'b1;
      preempt_hpi_d = preempt_hpi_q || (hold_cnt_d == HoldW'(MAX_HOLD));
    end else if (state_q == StOwnAce && state_d == StOwnAce) begin
      hold_cnt_d = hold_cnt_q;
      if (req_hpi && hold_cnt_q != HoldW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + 1'b1;
      preempt_ace_d = preempt_ace_q || (hold_cnt_d == HoldW'(MAX_HOLD));
    end
  end

  // Hold counter and preempt hint registers.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      hold_cnt_q    <= '0;
      preempt_hpi_q <= 1'b0;
      preempt_ace_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      preempt_hpi_q <= preempt_hpi_d;
      preempt_ace_q <= preempt_ace_d;
    end
  end

  assign preempt_hpi = preempt_hpi_q;
  assign preempt_ace = preempt_ace_q;
`else
  // Hold limit has no effect when the preempt hint is compiled out.
  logic unused_max_hold;
  assign unused_max_hold = |MAX_HOLD;
  assign preempt_hpi     = 1'b0;
  assign preempt_ace     = 1'b0;
`endif

  sace_bus_mux u_bus_mux (
    .sys_clk   (sys_clk),
    .usbreset  (usbreset),
    .sel       (mux_sel),
    .hpi_a     (hpi_a),
    .hpi_oen   (hpi_oen),
    .hpi_wen   (hpi_wen),
    .hpi_dout  (hpi_dout),
    .hpi_doe   (hpi_doe),
    .ace_a     (ace_a),
    .ace_oen   (ace_oen),
    .ace_wen   (ace_wen),
    .ace_dout  (ace_dout),
    .ace_doe   (ace_doe),
    .bus_a     (bus_a),
    .bus_oen   (bus_oen),
    .bus_wen   (bus_wen),
    .bus_d_out (bus_d_out),
    .bus_d_oe  (bus_d_oe)
  );

endmodule

// File: tb/tb_sace_bus_arbiter.sv
// Scoreboard bench for sace_bus_arbiter: a transaction-level reference model predicts the
// outputs after every clock edge, a negedge monitor pops and compares them.
module tb_sace_bus_arbiter;

  localparam int unsigned Turn    = 4;
  localparam int unsigned MaxHold = 8;

  typedef struct packed {
    logic        gnt_hpi;
    logic        gnt_ace;
    logic        usb_csn;
    logic        sace_mpce;
    logic [1:0]  owner;
    logic [6:0]  a;
    logic        oen;
    logic        wen;
    logic [15:0] dout;
    logic        doe;
    logic        pre_hpi;
    logic        pre_ace;
  } obs_t;

  logic        sys_clk  = 1'b0;
  logic        usbreset = 1'b1;
  logic        req_hpi  = 1'b0, req_ace = 1'b0;
  logic [1:0]  hpi_a    = '0;
  logic        hpi_oen  = 1'b1, hpi_wen = 1'b1, hpi_doe = 1'b0;
  logic [15:0] hpi_dout = '0;
  logic [6:0]  ace_a    = '0;
  logic        ace_oen  = 1'b1, ace_wen = 1'b1, ace_doe = 1'b0;
  logic [15:0] ace_dout = '0;
  logic        gnt_hpi, gnt_ace, preempt_hpi, preempt_ace;
  logic [6:0]  bus_a;
  logic        bus_oen, bus_wen, bus_d_oe, usb_csn, sace_mpce;
  logic [15:0] bus_d_out;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t exp_q[$];

  // Reference model: who owns the bus (0 none, 1 HPI, 2 ACE), gap cycles left, last winner.
  int          m_owner = 0, m_turn = 0, m_last = 2, m_hold = 0;
  bit          m_pre   = 1'b0;
  logic [6:0]  m_a     = '0;
  logic        m_oen   = 1'b1, m_wen = 1'b1, m_doe = 1'b0;
  logic [15:0] m_dout  = '0;

  sace_bus_arbiter #(
    .TURNAROUND_CYCLES (Turn),
    .MAX_HOLD          (MaxHold)
  ) dut (
    .sys_clk     (sys_clk),
    .usbreset    (usbreset),
    .req_hpi     (req_hpi),
    .req_ace     (req_ace),
    .gnt_hpi     (gnt_hpi),
    .gnt_ace     (gnt_ace),
    .preempt_hpi (preempt_hpi),
    .preempt_ace (preempt_ace),
    .hpi_a       (hpi_a),
    .hpi_oen     (hpi_oen),
    .hpi_wen     (hpi_wen),
    .hpi_dout    (hpi_dout),
    .hpi_doe     (hpi_doe),
    .ace_a       (ace_a),
    .ace_oen     (ace_oen),
    .ace_wen     (ace_wen),
    .ace_dout    (ace_dout),
    .ace_doe     (ace_doe),
    .bus_a       (bus_a),
    .bus_oen     (bus_oen),
    .bus_wen     (bus_wen),
    .bus_d_out   (bus_d_out),
    .bus_d_oe    (bus_d_oe),
    .usb_csn     (usb_csn),
    .sace_mpce   (sace_mpce),
    .owner       (owner)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.gnt_hpi   = (m_owner == 1);
    o.gnt_ace   = (m_owner == 2);
    o.usb_csn   = (m_owner != 1);
    o.sace_mpce = (m_owner != 2);
    o.owner     = 2'(m_owner);
    o.a         = m_a;
    o.oen       = m_oen;
    o.wen       = m_wen;
    o.dout      = m_dout;
    o.doe       = m_doe;
    o.pre_hpi   = m_pre && (m_owner == 1);
    o.pre_ace   = m_pre && (m_owner == 2);
    return o;
  endfunction

  function automatic obs_t dut_out();
    return {gnt_hpi, gnt_ace, usb_csn, sace_mpce, owner, bus_a, bus_oen, bus_wen,
            bus_d_out, bus_d_oe, preempt_hpi, preempt_ace};
  endfunction

  // Model step on every edge; pushes the predicted post-edge outputs.
  always @(posedge sys_clk or posedge usbreset) begin
    bit mine;
    bit other;
    if (usbreset) begin
      exp_q.delete();
      m_owner = 0; m_turn = 0; m_last = 2; m_hold = 0; m_pre = 1'b0;
      m_a = '0; m_oen = 1'b1; m_wen = 1'b1; m_dout = '0; m_doe = 1'b0;
    end else if (m_owner == 0) begin
      m_a = '0; m_oen = 1'b1; m_wen = 1'b1; m_dout = '0; m_doe = 1'b0;
      if (m_turn > 0) m_turn--;
      else if (req_hpi && (!req_ace || m_last == 2)) begin m_owner = 1; m_last = 1; end
      else if (req_ace) begin m_owner = 2; m_last = 2; end
    end else begin
      mine  = (m_owner == 1) ? req_hpi : req_ace;
      other = (m_owner == 1) ? req_ace : req_hpi;
      if (!mine) begin
        m_owner = 0; m_turn = Turn; m_hold = 0; m_pre = 1'b0;
        m_a = '0; m_oen = 1'b1; m_wen = 1'b1; m_dout = '0; m_doe = 1'b0;
      end else begin
        if (m_owner == 1) begin
          m_a = {4'b0000, hpi_a, 1'b0}; m_oen = hpi_oen; m_wen = hpi_wen;
          m_dout = hpi_dout; m_doe = hpi_doe;
        end else begin
          m_a = ace_a; m_oen = ace_oen; m_wen = ace_wen; m_dout = ace_dout; m_doe = ace_doe;
        end
`ifdef SACE_ARB_PREEMPT_EN
        if (other && m_hold < int'(MaxHold)) m_hold++;
        if (m_hold >= int'(MaxHold)) m_pre = 1'b1;
`else
        if (other) m_hold = 0;
`endif
      end
    end
    exp_q.push_back(model_out());
  end

  // Monitor: mutual exclusion every cycle, then the scoreboard entry for this cycle.
  always @(negedge sys_clk) begin
    obs_t want;
    check("exclusive_grant_cs",
          64'((gnt_hpi === 1'b1 && gnt_ace === 1'b1) ||
              (usb_csn === 1'b0 && sace_mpce === 1'b0)), 64'd0);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("scoreboard", 64'(dut_out()), 64'(want));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_strobes();
    hpi_a = '0; hpi_oen = 1'b1; hpi_wen = 1'b1; hpi_dout = '0; hpi_doe = 1'b0;
    ace_a = '0; ace_oen = 1'b1; ace_wen = 1'b1; ace_dout = '0; ace_doe = 1'b0;
  endtask

  task automatic check_released(input string name);
    check({name, "_gnt"}, 64'({gnt_hpi, gnt_ace}), 64'd0);
    check({name, "_cs"}, 64'({usb_csn, sace_mpce}), 64'b11);
    check({name, "_bus"}, 64'({bus_a, bus_oen, bus_wen, bus_d_out, bus_d_oe}),
          64'({7'd0, 1'b1, 1'b1, 16'd0, 1'b0}));
    check({name, "_owner_pre"}, 64'({owner, preempt_hpi, preempt_ace}), 64'd0);
  endtask

  initial begin
    int gap;
    bit seen;

    // Reset state.
    step(3);
    check_released("reset");
    usbreset = 1'b0;
    step(2);

    // Lone HPI request is granted one edge later.
    req_hpi = 1'b1;
    step(1);
    check("hpi_grant", 64'({gnt_hpi, usb_csn, sace_mpce, owner}), 64'({1'b1, 1'b0, 1'b1, 2'b01}));

    // HPI strobes appear on the bus one cycle later with the address shifted up by one.
    hpi_a = 2'b11; hpi_wen = 1'b0; hpi_dout = 16'hBEEF; hpi_doe = 1'b1;
    step(1);
    check("hpi_bus", 64'({bus_a, bus_wen, bus_d_out, bus_d_oe}),
          64'({7'b0000110, 1'b0, 16'hBEEF, 1'b1}));
    req_hpi = 1'b0;
    idle_strobes();
    step(Turn + 3);

    // Simultaneous requests from reset: HPI wins, ACE follows after the turnaround gap.
    usbreset = 1'b1;
    step(1);
    usbreset = 1'b0;
    req_hpi = 1'b1; req_ace = 1'b1;
    step(1);
    check("tie_hpi_first", 64'({gnt_hpi, gnt_ace}), 64'b10);
    step(3);
    req_hpi = 1'b0;
    step(1);
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (gnt_ace === 1'b1) seen = 1'b1;
      else begin
        if (usb_csn === 1'b1 && sace_mpce === 1'b1) gap++;
        step(1);
      end
    end
    check("ace_after_turn_seen", 64'(seen), 64'd1);
    check("turn_gap_min", 64'(gap >= int'(Turn)), 64'd1);

    // ACE holds while HPI waits long enough to trip the hold limit.
    ace_a = 7'h55; ace_wen = 1'b0; ace_dout = 16'h1234; ace_doe = 1'b1;
    req_hpi = 1'b1;
    step(MaxHold + 4);
`ifdef SACE_ARB_PREEMPT_EN
    check("preempt_ace_set", 64'(preempt_ace), 64'd1);
`else
    check("preempt_ace_off", 64'(preempt_ace), 64'd0);
`endif
    check("ace_still_owner", 64'({gnt_ace, bus_d_oe}), 64'b11);

    // Asynchronous reset mid-cycle releases the bus without waiting for a clock.
    #1 usbreset = 1'b1;
    #1;
    check("async_rst", 64'({sace_mpce, bus_d_oe, gnt_ace}), 64'b100);
    check_released("async_rst_all");
    step(1);
    usbreset = 1'b0;
    req_hpi = 1'b0; req_ace = 1'b0;
    idle_strobes();
    step(2);

    // Random soak: sticky requests, random strobes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req_hpi = ~req_hpi;
      if ($urandom_range(0, 7) == 0) req_ace = ~req_ace;
      hpi_a = 2'($urandom); hpi_oen = 1'($urandom); hpi_wen = 1'($urandom);
      hpi_dout = 16'($urandom); hpi_doe = 1'($urandom);
      ace_a = 7'($urandom); ace_oen = 1'($urandom); ace_wen = 1'($urandom);
      ace_dout = 16'($urandom); ace_doe = 1'($urandom);
      step(1);
    end
    req_hpi = 1'b0; req_ace = 1'b0;
    idle_strobes();
    step(Turn + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sace_bus_arbiter.md
SACE_BUS_ARBITER -- requirements
Module: sace_bus_arbiter

Interface
REQ-001 Parameter TURNAROUND_CYCLES, default 4; idle sys_clk cycles with both chip selects deasserted between owners.
REQ-002 Parameter MAX_HOLD, default 256; cycles an owner may hold the bus while the other side waits before preempt is raised.
REQ-003 sys_clk  in  1  system clock, 100 MHz; usbreset  in  1  asynchronous, active-high reset.
REQ-004 req_hpi, req_ace  in  1 each  bus requests; level-held for the whole transaction.
REQ-005 gnt_hpi, gnt_ace  out  1 each  one-hot-or-zero grants.
REQ-006 preempt_hpi, preempt_ace  out  1 each  owner must finish and drop its request.
REQ-007 hpi_a  in  2, hpi_oen/hpi_wen  in  1, hpi_dout  in  16, hpi_doe  in  1  HPI-side strobes/data.
REQ-008 ace_a  in  7, ace_oen/ace_wen  in  1, ace_dout  in  16, ace_doe  in  1  ACE-side strobes/data.
REQ-009 bus_a  out  7, bus_oen/bus_wen  out  1, bus_d_out  out  16, bus_d_oe  out  1  shared bus drive.
REQ-010 usb_csn  out  1, sace_mpce  out  1  active-low chip selects, CY7C67300 and System ACE.
REQ-011 owner  out  2  00 none, 01 HPI, 10 ACE.

Function
REQ-012 FSM states IDLE, OWN_HPI, OWN_ACE, TURN; state and all outputs are registered.
REQ-013 IDLE: single request is granted next cycle; both requesting grants the side not in last_owner.
REQ-014 Grant asserts together with its chip select (usb_csn=0 or sace_mpce=0) and owner code.
REQ-015 OWN_x: bus_a/oen/wen/d_out/d_oe follow the owner's inputs registered, one-cycle latency; HPI address maps to bus_a[2:1], other bus_a bits 0.
REQ-016 OWN_x exits to TURN on the cycle the owner's request is seen low; grant and chip select drop that same edge.
REQ-017 TURN: both chip selects 1, bus_oen=bus_wen=1, bus_d_oe=0, bus_a=0, owner=00, held exactly TURNAROUND_CYCLES cycles, then IDLE.
REQ-018 TURNAROUND_CYCLES=0 skips TURN and goes straight to IDLE.
REQ-019 Requests arriving during TURN are arbitrated in IDLE; no request is lost while it stays asserted.
REQ-020 Never both grants, never both chip selects low, in any cycle including reset release.
REQ-021 A requester that drops and re-raises request in the same TURN window still loses a tie to the waiting side (round-robin via last_owner).
REQ-022 Outside an owned state, owner strobe inputs are ignored.

Reset
REQ-023 usbreset: state IDLE, gnt_*=0, preempt_*=0, usb_csn=1, sace_mpce=1, bus_oen=bus_wen=1, bus_d_oe=0, bus_a=0, bus_d_out=0, owner=00, last_owner=ACE (HPI wins first tie), counters 0.
REQ-024 Reset mid-transaction releases the bus on the asserting edge, no turnaround required afterward.

Configuration
REQ-025 Macro SACE_ARB_PREEMPT_EN defined: hold counter counts owned cycles while other side requests; at MAX_HOLD it raises preempt_<owner> until that request drops; counter clears on leaving the owned state.
REQ-026 Without SACE_ARB_PREEMPT_EN: no hold counter, preempt_hpi and preempt_ace tied 0, MAX_HOLD ignored.
REQ-027 Preempt is advisory; the grant is never forcibly removed while the request is held.

Structure
REQ-028 Shared package stierlitz_pkg holds FSM state encodings and OWNER_NONE/HPI/ACE constants.
REQ-029 Registered output steering lives in sub-module sace_bus_mux (owner select in, registered bus drive out); FSM and counters stay in sace_bus_arbiter.

Verification
REQ-030 Reset, then req_hpi=1 alone -> gnt_hpi=1, usb_csn=0, sace_mpce=1, owner=01 one cycle later.
REQ-031 req_hpi and req_ace raised same cycle from reset -> HPI granted; HPI drops -> 4 TURN cycles with both CS high, then gnt_ace=1.
REQ-032 HPI owner, hpi_a=2'b11, hpi_wen=0, hpi_dout=16'hBEEF, hpi_doe=1 -> next cycle bus_a=7'b0000110, bus_wen=0, bus_d_out=16'hBEEF, bus_d_oe=1.
REQ-033 SACE_ARB_PREEMPT_EN, MAX_HOLD=8, ACE holds, HPI waits -> preempt_ace=1 after 8 waiting cycles, held until req_ace=0; without macro preempt stays 0.
REQ-034 usbreset pulsed while ACE owns with bus_d_oe=1 -> same edge sace_mpce=1, bus_d_oe=0, gnt_ace=0; random-request soak asserts REQ-020 every cycle.
